mem_access_stage: RTL and testbench

MEM_ACCESS_STAGE -- requirements
Module: mem_access_stage

---
 rtl/mem_access_stage.sv | 155 +++++++++++++++
 tb/tb_mem_access_stage.sv | 294 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_access_stage.sv
// MEM pipeline stage: drives the data-memory port for loads/stores (byte, word,
// indirect) and loads the MEM/WB register, stalling upstream while memory is busy.
//
// state  | meaning
// IDLE   | no access in flight; pass ALU results through or accept a memory op
// IND_RD | reading the pointer word of an indirect op
// ACCESS | performing the final load/store, waiting on dmem_resp
module mem_access_stage (
  input  logic        clk,
  input  logic        reset,
  input  logic        in_valid,
  input  logic        in_mem_read,
  input  logic        in_mem_write,
  input  logic        in_byte,
  input  logic        in_indirect,
  input  logic [15:0] in_addr,
  input  logic [15:0] in_store_data,
  input  logic [2:0]  in_dest,
  input  logic        in_load_regfile,
  output logic [15:0] dmem_address,
  output logic        dmem_read,
  output logic        dmem_write,
  output logic [1:0]  dmem_byte_enable,
  output logic [15:0] dmem_wdata,
  input  logic [15:0] dmem_rdata,
  input  logic        dmem_resp,
  output logic        stall,
  output logic        wb_valid,
  output logic [15:0] wb_data,
  output logic [2:0]  wb_dest,
  output logic        wb_load_regfile
);

  typedef enum logic [1:0] {IDLE, IND_RD, ACCESS} state_t;

  state_t      state, state_nxt;

  logic        lat_read;
  logic        lat_byte;
  logic [15:0] lat_addr;
  logic [15:0] lat_data;
  logic [2:0]  lat_dest;
  logic        lat_lr;

  logic        wb_valid_nxt;
  logic        wb_lr_nxt;
  logic [15:0] wb_data_nxt;
  logic [2:0]  wb_dest_nxt;

  logic        mem_op;
  logic [1:0]  access_be;
  logic [15:0] load_result;

  // Read+write together is treated as a read, so in_mem_read alone selects the direction.
  assign mem_op = in_valid & (in_mem_read | in_mem_write);

  assign access_be   = lat_byte ? (lat_addr[0] ? 2'b10 : 2'b01) : 2'b11;
  assign load_result = lat_byte ? {8'h00, (lat_addr[0] ? dmem_rdata[15:8] : dmem_rdata[7:0])}
                                : dmem_rdata;

  assign dmem_address = lat_addr;
  assign dmem_wdata   = lat_byte ? {lat_data[7:0], lat_data[7:0]} : lat_data;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt        = state;
    stall            = 1'b0;
    dmem_read        = 1'b0;
    dmem_write       = 1'b0;
    dmem_byte_enable = 2'b00;
    wb_valid_nxt     = 1'b0;
    wb_lr_nxt        = 1'b0;
    wb_data_nxt      = wb_data;
    wb_dest_nxt      = wb_dest;
    case (state)
      IDLE: begin
        if (mem_op) begin
          stall     = 1'b1;
          state_nxt = in_indirect ? IND_RD : ACCESS;
        end else if (in_valid) begin
          wb_valid_nxt = 1'b1;
          wb_data_nxt  = in_addr;
          wb_dest_nxt  = in_dest;
          wb_lr_nxt    = in_load_regfile;
        end
      end
      IND_RD: begin
        stall            = 1'b1;
        dmem_read        = 1'b1;
        dmem_byte_enable = 2'b11;
        if (dmem_resp) begin
          state_nxt = ACCESS;
        end
      end
      ACCESS: begin
        stall            = ~dmem_resp;
        dmem_read        = lat_read;
        dmem_write       = ~lat_read;
        dmem_byte_enable = access_be;
        if (dmem_resp) begin
          wb_valid_nxt = 1'b1;
          wb_data_nxt  = load_result;
          wb_dest_nxt  = lat_dest;
          wb_lr_nxt    = lat_lr;
          state_nxt    = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Operand latch: captured on acceptance; the address is replaced by the pointer
  // once the indirect read returns.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      lat_read <= 1'b0;
      lat_byte <= 1'b0;
      lat_addr <= 16'h0000;
      lat_data <= 16'h0000;
      lat_dest <= 3'd0;
      lat_lr   <= 1'b0;
    end else if (state == IDLE && mem_op) begin
      lat_read <= in_mem_read;
      lat_byte <= in_byte;
      lat_addr <= in_addr;
      lat_data <= in_store_data;
      lat_dest <= in_dest;
      lat_lr   <= in_load_regfile & in_mem_read;
    end else if (state == IND_RD && dmem_resp) begin
      lat_addr <= dmem_rdata;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wb_valid        <= 1'b0;
      wb_load_regfile <= 1'b0;
      wb_data         <= 16'h0000;
      wb_dest         <= 3'd0;
    end else begin
      wb_valid        <= wb_valid_nxt;
      wb_load_regfile <= wb_lr_nxt;
      wb_data         <= wb_data_nxt;
      wb_dest         <= wb_dest_nxt;
    end
  end

endmodule

// File: tb/tb_mem_access_stage.sv
// Bench for mem_access_stage: directed vector table, reset-abort sequence, and
// random instruction stream checked against an instruction-level memory model.
module tb_mem_access_stage;

  logic        clk = 1'b0;
  logic        reset;
  logic        in_valid, in_mem_read, in_mem_write, in_byte, in_indirect, in_load_regfile;
  logic [15:0] in_addr, in_store_data;
  logic [2:0]  in_dest;
  logic [15:0] dmem_address, dmem_wdata, dmem_rdata;
  logic        dmem_read, dmem_write, dmem_resp;
  logic [1:0]  dmem_byte_enable;
  logic        stall, wb_valid, wb_load_regfile;
  logic [15:0] wb_data;
  logic [2:0]  wb_dest;

  always #5 clk = ~clk;

  mem_access_stage dut (
    .clk(clk), .reset(reset),
    .in_valid(in_valid), .in_mem_read(in_mem_read), .in_mem_write(in_mem_write),
    .in_byte(in_byte), .in_indirect(in_indirect), .in_addr(in_addr),
    .in_store_data(in_store_data), .in_dest(in_dest), .in_load_regfile(in_load_regfile),
    .dmem_address(dmem_address), .dmem_read(dmem_read), .dmem_write(dmem_write),
    .dmem_byte_enable(dmem_byte_enable), .dmem_wdata(dmem_wdata),
    .dmem_rdata(dmem_rdata), .dmem_resp(dmem_resp),
    .stall(stall), .wb_valid(wb_valid), .wb_data(wb_data), .wb_dest(wb_dest),
    .wb_load_regfile(wb_load_regfile)
  );

  typedef struct {
    logic v, rd, wr, byt, ind;
    logic [15:0] addr, sdata;
    logic [2:0] dest;
    logic lr;
  } instr_t;

  typedef struct {
    instr_t ins;
    logic [15:0] mem_a, mem_b;
    int lat, exp_cycles;
    logic exp_valid, chk_data;
    logic [15:0] exp_data;
    logic exp_lr;
    int exp_acc;
    logic exp_write;
    logic [1:0] exp_be;
    logic [15:0] exp_wdata, exp_last_addr;
  } vec_t;

  int checks = 0;
  int errors = 0;

  logic [15:0] mem     [0:65535];
  logic [15:0] ref_mem [0:65535];

  int fixed_lat = 0;
  int wait_left = -1;
  int          lat_log[$];
  logic [15:0] addr_log[$];
  logic [1:0]  be_log[$];
  logic [15:0] wd_log[$];
  logic        wr_log[$];

  vec_t vq[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic instr_t mk(input logic v, rd, wr, byt, ind, input logic [15:0] a, sd,
                                input logic [2:0] d, input logic lr);
    instr_t i;
    i.v = v; i.rd = rd; i.wr = wr; i.byt = byt; i.ind = ind;
    i.addr = a; i.sdata = sd; i.dest = d; i.lr = lr;
    return i;
  endfunction

  // Memory responder: called just after a falling edge, once strobes are settled.
  task automatic respond();
    if (dmem_read || dmem_write) begin
      if (wait_left < 0) begin
        wait_left = (fixed_lat >= 0) ? fixed_lat : int'($urandom_range(0, 3));
        lat_log.push_back(wait_left);
        addr_log.push_back(dmem_address);
        be_log.push_back(dmem_byte_enable);
        wd_log.push_back(dmem_wdata);
        wr_log.push_back(dmem_write);
      end
      if (wait_left == 0) begin
        dmem_resp  = 1'b1;
        dmem_rdata = mem[dmem_address];
        if (dmem_write) begin
          if (dmem_byte_enable[0]) mem[dmem_address][7:0]  = dmem_wdata[7:0];
          if (dmem_byte_enable[1]) mem[dmem_address][15:8] = dmem_wdata[15:8];
        end
        wait_left = -1;
      end else begin
        dmem_resp  = 1'b0;
        dmem_rdata = 16'($urandom);
        wait_left--;
      end
    end else begin
      dmem_resp  = 1'b0;
      dmem_rdata = 16'($urandom);
      wait_left  = -1;
    end
  endtask

  // Holds one instruction on the inputs until the stage stops stalling.
  task automatic run_instr(input instr_t i, output int cycles, output logic o_valid,
                           output logic [15:0] o_data, output logic o_lr,
                           output logic [2:0] o_dest);
    logic st;
    bit done;
    lat_log.delete(); addr_log.delete(); be_log.delete(); wd_log.delete(); wr_log.delete();
    done = 0; cycles = 0;
    o_valid = 0; o_data = 0; o_lr = 0; o_dest = 0;
    @(negedge clk);
    in_valid = i.v; in_mem_read = i.rd; in_mem_write = i.wr; in_byte = i.byt;
    in_indirect = i.ind; in_addr = i.addr; in_store_data = i.sdata;
    in_dest = i.dest; in_load_regfile = i.lr;
    for (int c = 0; c < 60; c++) begin
      respond();
      #1;
      st = stall;
      cycles++;
      @(posedge clk);
      #1;
      if (!st) begin
        o_valid = wb_valid; o_data = wb_data; o_lr = wb_load_regfile; o_dest = wb_dest;
        done = 1;
        break;
      end
      check("stall_bubble_valid", wb_valid, 1'b0);
      @(negedge clk);
    end
    if (!done) check("instr_timeout", 1'b0, 1'b1);
  endtask

  int          cyc;
  logic        o_valid, o_lr;
  logic [15:0] o_data;
  logic [2:0]  o_dest;

  initial begin
    reset = 1'b1;
    in_valid = 0; in_mem_read = 0; in_mem_write = 0; in_byte = 0; in_indirect = 0;
    in_addr = 0; in_store_data = 0; in_dest = 0; in_load_regfile = 0;
    dmem_resp = 0; dmem_rdata = 0;
    for (int a = 0; a < 65536; a++) mem[a] = 16'($urandom);

    repeat (2) @(posedge clk);
    #1;
    check("rst_wb_valid", wb_valid, 1'b0);
    check("rst_wb_lr", wb_load_regfile, 1'b0);
    check("rst_wb_data", wb_data, 16'h0000);
    check("rst_wb_dest", wb_dest, 3'd0);
    check("rst_strobes", {dmem_read, dmem_write}, 2'b00);
    check("rst_stall", stall, 1'b0);
    @(negedge clk);
    reset = 1'b0;

    //          ins                                                       mem_a    mem_b   lat cyc vld chk data     lr acc wr be     wdata    last_addr
    vq.push_back('{mk(1,0,0,0,0,16'h1234,16'h0000,3,1), 16'h0000,16'h0000, 0, 1, 1, 1, 16'h1234, 1, 0, 0, 2'b00, 16'h0000, 16'h0000});
    vq.push_back('{mk(1,1,0,1,0,16'h2001,16'h0000,5,1), 16'hABCD,16'h0000, 4, 6, 1, 1, 16'h00AB, 1, 1, 0, 2'b10, 16'h0000, 16'h2001});
    vq.push_back('{mk(1,0,1,1,0,16'h3000,16'h00EF,2,1), 16'h0000,16'h0000, 1, 3, 1, 0, 16'h0000, 0, 1, 1, 2'b01, 16'hEFEF, 16'h3000});
    vq.push_back('{mk(1,1,0,0,1,16'h4000,16'h0000,6,1), 16'h5000,16'h0042, 2, 7, 1, 1, 16'h0042, 1, 2, 0, 2'b11, 16'h0000, 16'h5000});
    vq.push_back('{mk(1,1,0,0,0,16'h6003,16'h0000,1,1), 16'h1357,16'h0000, 0, 2, 1, 1, 16'h1357, 1, 1, 0, 2'b11, 16'h0000, 16'h6003});
    vq.push_back('{mk(1,1,0,1,0,16'h2000,16'h0000,4,0), 16'hABCD,16'h0000, 1, 3, 1, 1, 16'h00CD, 0, 1, 0, 2'b01, 16'h0000, 16'h2000});
    vq.push_back('{mk(1,0,1,1,0,16'h3001,16'h12A5,7,0), 16'h0000,16'h0000, 0, 2, 1, 0, 16'h0000, 0, 1, 1, 2'b10, 16'hA5A5, 16'h3001});
    vq.push_back('{mk(1,1,1,0,0,16'h7000,16'hFFFF,1,1), 16'h2468,16'h0000, 1, 3, 1, 1, 16'h2468, 1, 1, 0, 2'b11, 16'h0000, 16'h7000});
    vq.push_back('{mk(0,0,0,0,0,16'h5555,16'h0000,2,1), 16'h0000,16'h0000, 0, 1, 0, 0, 16'h0000, 0, 0, 0, 2'b00, 16'h0000, 16'h0000});
    vq.push_back('{mk(1,0,1,0,1,16'h8000,16'hBEEF,3,1), 16'h8100,16'h0000, 0, 3, 1, 0, 16'h0000, 0, 2, 1, 2'b11, 16'hBEEF, 16'h8100});
    vq.push_back('{mk(0,1,0,0,0,16'h9000,16'h0000,1,1), 16'h0000,16'h0000, 0, 1, 0, 0, 16'h0000, 0, 0, 0, 2'b00, 16'h0000, 16'h0000});

    foreach (vq[k]) begin
      mem[vq[k].ins.addr] = vq[k].mem_a;
      if (vq[k].ins.ind) mem[vq[k].mem_a] = vq[k].mem_b;
      fixed_lat = vq[k].lat;
      run_instr(vq[k].ins, cyc, o_valid, o_data, o_lr, o_dest);
      check($sformatf("v%0d_cycles", k), cyc, vq[k].exp_cycles);
      check($sformatf("v%0d_valid", k), o_valid, vq[k].exp_valid);
      check($sformatf("v%0d_lr", k), o_lr, vq[k].exp_lr);
      if (vq[k].exp_valid) check($sformatf("v%0d_dest", k), o_dest, vq[k].ins.dest);
      if (vq[k].chk_data) check($sformatf("v%0d_data", k), o_data, vq[k].exp_data);
      check($sformatf("v%0d_accesses", k), lat_log.size(), vq[k].exp_acc);
      if (vq[k].exp_acc > 0 && lat_log.size() > 0) begin
        check($sformatf("v%0d_addr", k), addr_log[$], vq[k].exp_last_addr);
        check($sformatf("v%0d_write", k), wr_log[$], vq[k].exp_write);
        check($sformatf("v%0d_be", k), be_log[$], vq[k].exp_be);
        if (vq[k].exp_write) check($sformatf("v%0d_wdata", k), wd_log[$], vq[k].exp_wdata);
      end
      if (vq[k].ins.ind && addr_log.size() > 0)
        check($sformatf("v%0d_ptr_addr", k), addr_log[0], vq[k].ins.addr);
    end

    // Reset while a read waits in ACCESS, then a stray response after release.
    fixed_lat = 20;
    @(negedge clk);
    in_valid = 1; in_mem_read = 1; in_mem_write = 0; in_byte = 0; in_indirect = 0;
    in_addr = 16'h9000; in_dest = 3'd4; in_load_regfile = 1;
    respond();
    @(posedge clk);
    @(negedge clk);
    respond();
    #1;
    check("abort_read_before", dmem_read, 1'b1);
    in_valid = 0; in_mem_read = 0;
    reset = 1'b1;
    #1;
    check("abort_read_dropped", dmem_read, 1'b0);
    check("abort_stall", stall, 1'b0);
    @(posedge clk);
    #1;
    check("abort_wb_valid", wb_valid, 1'b0);
    @(negedge clk);
    reset = 1'b0;
    wait_left = -1;
    dmem_resp = 1'b1;
    dmem_rdata = 16'hFFFF;
    for (int c = 0; c < 2; c++) begin
      @(posedge clk);
      #1;
      check("stray_resp_wb_valid", wb_valid, 1'b0);
      check("stray_resp_strobe", {dmem_read, dmem_write}, 2'b00);
      @(negedge clk);
    end
    dmem_resp = 1'b0;
    fixed_lat = 0;
    run_instr(mk(1,0,0,0,0,16'hC0DE,16'h0000,7,1), cyc, o_valid, o_data, o_lr, o_dest);
    check("post_reset_alu_data", o_data, 16'hC0DE);
    check("post_reset_alu_valid", o_valid, 1'b1);

    // Random stream against an instruction-level model of memory semantics.
    for (int a = 0; a < 65536; a++) ref_mem[a] = mem[a];
    fixed_lat = -1;
    for (int n = 0; n < 300; n++) begin
      instr_t i;
      logic is_mem, is_load;
      logic [15:0] eff, w, exp_data, exp_wd;
      logic [1:0] exp_be;
      logic exp_lr;
      int exp_acc, exp_cyc;
      i = mk($urandom_range(0, 9) != 0, 1'($urandom), 1'($urandom), 1'($urandom),
             1'($urandom), 16'($urandom), 16'($urandom), 3'($urandom), 1'($urandom));
      is_mem  = i.v && (i.rd || i.wr);
      is_load = i.rd;
      eff = i.ind ? ref_mem[i.addr] : i.addr;
      exp_data = i.addr; exp_lr = i.lr; exp_be = 2'b11; exp_wd = i.sdata;
      exp_acc = is_mem ? (i.ind ? 2 : 1) : 0;
      if (is_mem && is_load) begin
        w = ref_mem[eff];
        exp_data = !i.byt ? w : (eff[0] ? {8'h00, w[15:8]} : {8'h00, w[7:0]});
        if (i.byt) exp_be = eff[0] ? 2'b10 : 2'b01;
      end else if (is_mem) begin
        exp_lr = 1'b0;
        if (i.byt) begin
          exp_wd = {i.sdata[7:0], i.sdata[7:0]};
          if (eff[0]) begin exp_be = 2'b10; ref_mem[eff][15:8] = i.sdata[7:0]; end
          else        begin exp_be = 2'b01; ref_mem[eff][7:0]  = i.sdata[7:0]; end
        end else begin
          ref_mem[eff] = i.sdata;
        end
      end
      run_instr(i, cyc, o_valid, o_data, o_lr, o_dest);
      exp_cyc = 1;
      foreach (lat_log[q]) exp_cyc += lat_log[q] + 1;
      check("rnd_cycles", cyc, exp_cyc);
      check("rnd_accesses", lat_log.size(), exp_acc);
      check("rnd_valid", o_valid, i.v);
      if (i.v) begin
        check("rnd_lr", o_lr, exp_lr);
        check("rnd_dest", o_dest, i.dest);
        if (!is_mem || is_load) check("rnd_data", o_data, exp_data);
      end
      if (exp_acc > 0 && lat_log.size() == exp_acc) begin
        check("rnd_addr", addr_log[$], eff);
        check("rnd_write", wr_log[$], !is_load);
        check("rnd_be", be_log[$], exp_be);
        if (!is_load) check("rnd_wdata", wd_log[$], exp_wd);
        if (i.ind) check("rnd_ptr_be", be_log[0], 2'b11);
      end
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
